grain_keystream_xor: RTL and testbench

//  Consumes the serial Grain-128a keystream (1 bit/clk) and packs it into bytes in a small FIFO.

---
 rtl/grain_keystream_xor_pkg.sv | 17 +
 rtl/grain_keystream_xor_if.sv | 31 +++
 rtl/grain_keystream_xor_ks_byte_fifo.sv | 61 ++++++
 rtl/grain_keystream_xor.sv | 84 ++++++++
 tb/tb_grain_keystream_xor.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/grain_keystream_xor_pkg.sv
// Shared types and helpers for the keystream XOR block.
package grain_keystream_xor_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] ks_byte_t;

    // Shift one keystream bit into a partially assembled byte.
    // LSB-first shifts right so the first bit ends up in bit 0 after DATA_W shifts.
    function automatic ks_byte_t pack_bit(ks_byte_t sr, logic b, bit msb_first);
        if (msb_first) begin
            return {sr[DATA_W-2:0], b};
        end
        return {b, sr[DATA_W-1:1]};
    endfunction

endpackage

// File: rtl/grain_keystream_xor_if.sv
// Keystream, plaintext and ciphertext signals of the keystream XOR block.
interface grain_keystream_xor_if
    import grain_keystream_xor_pkg::*;
#(
    parameter int KS_DEPTH = 4
);
    localparam int LVL_W = $clog2(KS_DEPTH + 1);

    logic             ks_ready;
    logic             ks_bit;
    logic             ks_enable;
    logic             flush;
    ks_byte_t         pt_data;
    logic             pt_valid;
    logic             pt_ready;
    ks_byte_t         ct_data;
    logic             ct_valid;
    logic             ct_ready;
    logic [LVL_W-1:0] ks_level;

    modport master (
        output ks_ready, ks_bit, flush, pt_data, pt_valid, ct_ready,
        input  ks_enable, pt_ready, ct_data, ct_valid, ks_level
    );

    modport slave (
        input  ks_ready, ks_bit, flush, pt_data, pt_valid, ct_ready,
        output ks_enable, pt_ready, ct_data, ct_valid, ks_level
    );

endinterface

// File: rtl/grain_keystream_xor_ks_byte_fifo.sv
// Synchronous keystream byte FIFO with clear, occupancy count and head output.
module ks_byte_fifo
    import grain_keystream_xor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  ks_byte_t                     i_data,
    input  logic                         i_pop,
    output ks_byte_t                     o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    ks_byte_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Clear wins over everything; guards keep the count inside 0..DEPTH.
    assign w_do_push = i_push && !i_clear && (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = i_pop  && !i_clear && (r_count != '0);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage needs no reset; only occupied entries are ever read as valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/grain_keystream_xor.sv
// Packs the serial keystream into bytes and XORs them onto a byte stream.
module grain_keystream_xor
    import grain_keystream_xor_pkg::*;
#(
    parameter int KS_DEPTH  = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    grain_keystream_xor_if.slave bus
);
    localparam int LVL_W = $clog2(KS_DEPTH + 1);
    localparam int CNT_W = $clog2(DATA_W);

    ks_byte_t         r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    ks_byte_t         r_ct_data;
    logic             r_ct_valid;

    ks_byte_t         w_next_shift;
    ks_byte_t         w_head;
    logic [LVL_W-1:0] w_level;
    logic             w_ks_enable;
    logic             w_push;
    logic             w_pt_ready;
    logic             w_pop;

    assign w_next_shift = pack_bit(r_shift, bus.ks_bit, MSB_FIRST);

    // Enable stops as soon as the FIFO is full, even mid-byte; the partial byte just waits.
    assign w_ks_enable = !reset && bus.ks_ready && !bus.flush && (w_level < LVL_W'(KS_DEPTH));
    assign w_push      = w_ks_enable && (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_pt_ready  = !reset && (w_level != '0) && (!r_ct_valid || bus.ct_ready) && !bus.flush;
    assign w_pop       = bus.pt_valid && w_pt_ready;

    assign bus.ks_enable = w_ks_enable;
    assign bus.pt_ready  = w_pt_ready;
    assign bus.ct_data   = r_ct_data;
    assign bus.ct_valid  = r_ct_valid;
    assign bus.ks_level  = w_level;

    // Collector: one keystream bit per enabled edge, push on the last bit of a byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (bus.flush) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_ks_enable) begin
            r_shift   <= w_next_shift;
            r_bit_cnt <= w_push ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    // Output register: load on handshake, hold under backpressure, drop valid once taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ct_data  <= '0;
            r_ct_valid <= 1'b0;
        end else if (bus.flush) begin
            r_ct_valid <= 1'b0;
        end else if (w_pop) begin
            r_ct_data  <= bus.pt_data ^ w_head;
            r_ct_valid <= 1'b1;
        end else if (bus.ct_ready) begin
            r_ct_valid <= 1'b0;
        end
    end

    ks_byte_fifo #(
        .DEPTH (KS_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (bus.flush),
        .i_push  (w_push),
        .i_data  (w_next_shift),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_level)
    );

endmodule

// File: tb/tb_grain_keystream_xor.sv
// Bench for grain_keystream_xor: LSB-first and MSB-first instances against a queue model.
module tb_grain_keystream_xor;
    import grain_keystream_xor_pkg::*;

    logic       clk = 1'b0;
    logic       t_rst;
    logic       t_ksr, t_kb, t_fl, t_ptv, t_ctr;
    logic [7:0] t_ptd;

    int total = 0;
    int bad   = 0;

    bit         m_bits [$];
    logic [7:0] m_ks0 [$];
    logic [7:0] m_ks1 [$];
    logic       m_ctv;
    logic [7:0] m_ct0, m_ct1;

    bit pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    grain_keystream_xor_if #(.KS_DEPTH(4)) bus0 ();
    grain_keystream_xor_if #(.KS_DEPTH(4)) bus1 ();

    assign bus0.ks_ready = t_ksr;
    assign bus0.ks_bit   = t_kb;
    assign bus0.flush    = t_fl;
    assign bus0.pt_data  = t_ptd;
    assign bus0.pt_valid = t_ptv;
    assign bus0.ct_ready = t_ctr;
    assign bus1.ks_ready = t_ksr;
    assign bus1.ks_bit   = t_kb;
    assign bus1.flush    = t_fl;
    assign bus1.pt_data  = t_ptd;
    assign bus1.pt_valid = t_ptv;
    assign bus1.ct_ready = t_ctr;

    grain_keystream_xor #(.KS_DEPTH(4), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .reset(t_rst), .bus(bus0));
    grain_keystream_xor #(.KS_DEPTH(4), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .reset(t_rst), .bus(bus1));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ks_en();
        return !t_rst && t_ksr && !t_fl && (m_ks0.size() < 4);
    endfunction

    function automatic bit exp_pt_rdy();
        return !t_rst && (m_ks0.size() != 0) && (!m_ctv || t_ctr) && !t_fl;
    endfunction

    task automatic model_clear();
        m_bits.delete();
        m_ks0.delete();
        m_ks1.delete();
        m_ctv = 1'b0;
        m_ct0 = 8'h00;
        m_ct1 = 8'h00;
    endtask

    task automatic compare();
        chk("ks_enable0", int'(bus0.ks_enable), int'(exp_ks_en()));
        chk("ks_enable1", int'(bus1.ks_enable), int'(exp_ks_en()));
        chk("pt_ready0",  int'(bus0.pt_ready),  int'(exp_pt_rdy()));
        chk("pt_ready1",  int'(bus1.pt_ready),  int'(exp_pt_rdy()));
        chk("ks_level0",  int'(bus0.ks_level),  m_ks0.size());
        chk("ks_level1",  int'(bus1.ks_level),  m_ks1.size());
        chk("ct_valid0",  int'(bus0.ct_valid),  int'(m_ctv));
        chk("ct_valid1",  int'(bus1.ct_valid),  int'(m_ctv));
        if (m_ctv) begin
            chk("ct_data0", int'(bus0.ct_data), int'(m_ct0));
            chk("ct_data1", int'(bus1.ct_data), int'(m_ct1));
        end
    endtask

    task automatic model_edge();
        bit         ken, prd;
        logic [7:0] b0, b1;
        ken = exp_ks_en();
        prd = exp_pt_rdy();
        if (t_fl) begin
            m_bits.delete();
            m_ks0.delete();
            m_ks1.delete();
            m_ctv = 1'b0;
        end else begin
            if (t_ptv && prd) begin
                m_ct0 = t_ptd ^ m_ks0.pop_front();
                m_ct1 = t_ptd ^ m_ks1.pop_front();
                m_ctv = 1'b1;
            end else if (t_ctr) begin
                m_ctv = 1'b0;
            end
            if (ken) begin
                m_bits.push_back(t_kb);
                if (m_bits.size() == 8) begin
                    for (int i = 0; i < 8; i++) begin
                        b0[i]     = m_bits[i];
                        b1[7 - i] = m_bits[i];
                    end
                    m_ks0.push_back(b0);
                    m_ks1.push_back(b1);
                    m_bits.delete();
                end
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic ksr, input logic kb, input logic fl,
                         input logic ptv, input logic [7:0] ptd, input logic ctr);
        t_ksr = ksr; t_kb = kb; t_fl = fl; t_ptv = ptv; t_ptd = ptd; t_ctr = ctr;
        #1 compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic feed_pat(input int first, input int last);
        for (int i = first; i <= last; i++) cycle(1'b1, pat[i], 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic feed_rand(input int n, input logic ctr);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0, 8'h00, ctr);
    endtask

    task automatic flush_all();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic async_reset();
        #2 t_rst = 1'b1;
        #1 model_clear();
        compare();
        chk("rst_ct_data0", int'(bus0.ct_data), 0);
        chk("rst_ct_data1", int'(bus1.ct_data), 0);
        @(posedge clk);
        @(negedge clk);
        t_rst = 1'b0;
    endtask

    initial begin
        t_rst = 1'b1;
        t_ksr = 1'b1; t_kb = 1'b0; t_fl = 1'b0; t_ptv = 1'b0; t_ptd = 8'h00; t_ctr = 1'b0;
        model_clear();
        #1 compare();
        chk("init_ct_data0", int'(bus0.ct_data), 0);
        @(negedge clk);
        t_rst = 1'b0;

        // Byte 1,0,1,1,0,0,0,1 -> 0x8D LSB-first, 0xB1 MSB-first
        feed_pat(0, 7);
        chk("t1_level", int'(bus0.ks_level), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1);
        chk("t1_ct_valid", int'(bus0.ct_valid), 1);
        chk("t1_ct0", int'(bus0.ct_data), 8'hCC);
        chk("t1_ct1", int'(bus1.ct_data), 8'hF0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        flush_all();
        feed_pat(0, 7);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("t2_ct1", int'(bus1.ct_data), 8'hB1);
        chk("t2_ct0", int'(bus0.ct_data), 8'h8D);

        // Fill to full, then one pop re-enables collection for one more byte
        flush_all();
        feed_rand(32, 1'b0);
        chk("t3_level_full", int'(bus0.ks_level), 4);
        chk("t3_ks_enable_off", int'(bus0.ks_enable), 0);
        cycle(1'b1, 1'($urandom), 1'b0, 1'b1, 8'($urandom), 1'b1);
        chk("t3_level_pop", int'(bus0.ks_level), 3);
        chk("t3_ks_enable_on", int'(bus0.ks_enable), 1);
        feed_rand(8, 1'b1);
        chk("t3_level_refill", int'(bus0.ks_level), 4);

        // Backpressure with a pending output byte
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        chk("t4_level", int'(bus0.ks_level), 3);
        chk("t4_pt_ready", int'(bus0.pt_ready), 0);
        chk("t4_ct_valid", int'(bus0.ct_valid), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Flush with two bytes buffered, a partial byte and a pending output
        flush_all();
        feed_rand(24, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
        feed_rand(5, 1'b0);
        chk("t5_level_pre", int'(bus0.ks_level), 2);
        chk("t5_ctv_pre", int'(bus0.ct_valid), 1);
        cycle(1'b1, 1'($urandom), 1'b1, 1'b0, 8'h00, 1'b0);
        chk("t5_level_post", int'(bus0.ks_level), 0);
        chk("t5_ctv_post", int'(bus0.ct_valid), 0);
        feed_pat(0, 7);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("t5_ct0", int'(bus0.ct_data), 8'h8D);
        chk("t5_ct1", int'(bus1.ct_data), 8'hB1);

        // Async reset mid-byte, then a ks_ready pause mid-byte
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        feed_pat(0, 2);
        async_reset();
        feed_pat(0, 2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("t6_level_pause", int'(bus0.ks_level), 0);
        feed_pat(3, 7);
        chk("t6_level", int'(bus0.ks_level), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("t6_ct0", int'(bus0.ct_data), 8'h8D);
        chk("t6_ct1", int'(bus1.ct_data), 8'hB1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'(($urandom % 8) != 0), 1'($urandom), 1'(($urandom % 64) == 0),
                  1'($urandom), 8'($urandom), 1'(($urandom % 10) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
